// File: rtl/red_seq_if.sv
// red_seq_if: start/operand request and busy/done/result reply
// for the nibble-serial RED reduction unit.
interface red_seq_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Result;

  modport master (
    output start,
    output A,
    output B,
    input  busy,
    input  done,
    input  Result
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output busy,
    output done,
    output Result
  );
endinterface

// File: rtl/red_seq.sv
// red_seq: RED = sext sum of four signed bytes, computed
// nibble-serially on one shared 4-bit adder with a registered carry.
module red_seq (
  input  logic      clk,
  input  logic      rst,
  red_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic [15:0] ra;
  logic [15:0] rb;
  logic [11:0] s1;
  logic [11:0] s2;
  logic [11:0] t;
  logic        cy;
  logic [1:0]  nib;
  logic [1:0]  op;
  logic        busy_q;
  logic        done_q;
  logic [15:0] res_q;

  logic [11:0] xa;
  logic [11:0] xb;
  logic [3:0]  xn;
  logic [3:0]  yn;
  logic        cin;
  logic [4:0]  sum;
  logic [11:0] dst;
  logic [11:0] dst_n;
  logic        last;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.Result = res_q;

  // operand select: high bytes, low bytes, then the two partials
  always_comb begin
    xa = '0;
    xb = '0;
    unique case (1'b1)
      (op == 2'd0): begin
        xa = {{4{ra[15]}}, ra[15:8]};
        xb = {{4{rb[15]}}, rb[15:8]};
      end
      (op == 2'd1): begin
        xa = {{4{ra[7]}}, ra[7:0]};
        xb = {{4{rb[7]}}, rb[7:0]};
      end
      default: begin
        xa = s1;
        xb = s2;
      end
    endcase
  end

  always_comb begin
    xn = 4'h0;
    yn = 4'h0;
    unique case (1'b1)
      (nib == 2'd0): begin
        xn = xa[3:0];
        yn = xb[3:0];
      end
      (nib == 2'd1): begin
        xn = xa[7:4];
        yn = xb[7:4];
      end
      default: begin
        xn = xa[11:8];
        yn = xb[11:8];
      end
    endcase
  end

  // carry chain restarts at nibble 0 of every op
  assign cin = (nib != 2'd0) & cy;
  assign sum = {1'b0, xn} + {1'b0, yn} + {4'b0, cin};

  always_comb begin
    dst = t;
    unique case (1'b1)
      (op == 2'd0): dst = s1;
      (op == 2'd1): dst = s2;
      default:      dst = t;
    endcase
  end

  always_comb begin
    dst_n = dst;
    unique case (1'b1)
      (nib == 2'd0): dst_n[3:0]  = sum[3:0];
      (nib == 2'd1): dst_n[7:4]  = sum[3:0];
      default:       dst_n[11:8] = sum[3:0];
    endcase
  end

  assign last = (op == 2'd2) && (nib == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      s1     <= '0;
      s2     <= '0;
      t      <= '0;
      cy     <= 1'b0;
      nib    <= '0;
      op     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            ra     <= bus.A;
            rb     <= bus.B;
            s1     <= '0;
            s2     <= '0;
            t      <= '0;
            cy     <= 1'b0;
            nib    <= '0;
            op     <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
        CALC: begin
          unique case (1'b1)
            (op == 2'd0): s1 <= dst_n;
            (op == 2'd1): s2 <= dst_n;
            default:      t  <= dst_n;
          endcase
          cy <= sum[4];
          if (nib == 2'd2) begin
            nib <= '0;
            op  <= op + 2'd1;
          end else begin
            nib <= nib + 2'd1;
          end
          if (last) begin
            op     <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            res_q  <= {{4{dst_n[11]}}, dst_n};
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(busy_q && done_q));
    end
  end

endmodule
